// File: rtl/led_pattern_pkg.sv
// Shared types and helpers for the LED pattern generator.
// Mode encodings match the cfg_mode_i field of the config port.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_e;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode/period registers, tick counter, blink phase,
// breathe duty/direction and the registered LED drive.
module led_channel
    import led_pattern_pkg::*;
#(
    parameter int unsigned PWM_BITS       = 8,
    parameter int unsigned PERIOD_W       = 16,
    parameter int unsigned DEFAULT_PERIOD = 500
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_i,
    input  logic                wr_i,
    input  mode_e               mode_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic [PWM_BITS-1:0] pwm_i,
    output logic                led_o
);

    mode_e               mode_q, mode_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                dir_down_q, dir_down_d;
    logic                led_q, led_d;
    logic                step_hit;

    // A zero period behaves as one: every tick is a step.
    assign step_hit = (period_q == '0) || (cnt_q == period_q - 1'b1);

    always_comb begin
        mode_d     = mode_q;
        period_d   = period_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        duty_d     = duty_q;
        dir_down_d = dir_down_q;
        led_d      = 1'b0;

        unique case (mode_q)
            MODE_OFF, MODE_ON: begin
                cnt_d      = '0;
                phase_d    = 1'b0;
                duty_d     = '0;
                dir_down_d = 1'b0;
            end
            MODE_BLINK: begin
                if (tick_i) begin
                    if (step_hit) begin
                        cnt_d   = '0;
                        phase_d = ~phase_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            MODE_BREATHE: begin
                if (tick_i) begin
                    if (step_hit) begin
                        cnt_d = '0;
                        // At either end the direction flips and duty holds for that step.
                        if (!dir_down_q) begin
                            if (duty_q == {PWM_BITS{1'b1}}) dir_down_d = 1'b1;
                            else                            duty_d     = duty_q + 1'b1;
                        end else begin
                            if (duty_q == '0) dir_down_d = 1'b0;
                            else              duty_d     = duty_q - 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase

        if (wr_i) begin
            mode_d     = mode_i;
            period_d   = period_i;
            cnt_d      = '0;
            phase_d    = 1'b0;
            duty_d     = '0;
            dir_down_d = 1'b0;
        end

        unique case (mode_q)
            MODE_OFF:     led_d = 1'b0;
            MODE_ON:      led_d = 1'b1;
            MODE_BLINK:   led_d = phase_q;
            MODE_BREATHE: led_d = (pwm_i < duty_q);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_OFF;
            period_q   <= PERIOD_W'(DEFAULT_PERIOD);
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            duty_q     <= '0;
            dir_down_q <= 1'b0;
            led_q      <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            duty_q     <= duty_d;
            dir_down_q <= dir_down_d;
            led_q      <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler and PWM counter,
// config write decode, and one led_channel per LED.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int unsigned NUM_LEDS       = 3,
    parameter int unsigned CLK_HZ         = 12_000_000,
    parameter int unsigned TICK_HZ        = 1_000,
    parameter int unsigned PWM_BITS       = 8,
    parameter int unsigned PERIOD_W       = 16,
    parameter int unsigned DEFAULT_PERIOD = 500
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [2:0]          cfg_chan_i,
    input  logic [1:0]          cfg_mode_i,
    input  logic [PERIOD_W-1:0] cfg_period_i,
    output logic                cfg_err_o,
    output logic                tick_o,
    output logic [NUM_LEDS-1:0] led_o
);

    localparam int unsigned DIV   = calc_div(CLK_HZ, TICK_HZ);
    localparam int unsigned PRE_W = $clog2(DIV);

    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic                pre_last;
    logic                accept;
    logic                chan_ok;

    assign pre_last = (pre_cnt_q == PRE_W'(DIV - 1));
    assign accept   = cfg_valid_i && ready_q;
    assign chan_ok  = (32'(cfg_chan_i) < NUM_LEDS);

    always_comb begin
        pre_cnt_d = pre_last ? '0 : pre_cnt_q + 1'b1;
        pwm_d     = pwm_q + 1'b1;
        ready_d   = 1'b1;
        err_d     = accept && !chan_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
            pwm_q     <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pwm_q     <= pwm_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    assign tick_o      = pre_last;
    assign cfg_ready_o = ready_q;
    assign cfg_err_o   = err_q;

    for (genvar n = 0; n < NUM_LEDS; n++) begin : g_chan
        logic wr;
        assign wr = accept && (32'(cfg_chan_i) == n);

        led_channel #(
            .PWM_BITS       (PWM_BITS),
            .PERIOD_W       (PERIOD_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick_i   (pre_last),
            .wr_i     (wr),
            .mode_i   (mode_e'(cfg_mode_i)),
            .period_i (cfg_period_i),
            .pwm_i    (pwm_q),
            .led_o    (led_o[n])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: directed table, corner sequences and
// random config traffic checked against a tick-counting reference model.
module tb_led_pattern_gen;

    localparam int NL = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic [2:0]  cfg_chan_i = '0;
    logic [1:0]  cfg_mode_i = '0;
    logic [15:0] cfg_period_i = '0;
    logic        cfg_err_o;
    logic        tick_o;
    logic [NL-1:0] led_o;

    led_pattern_gen #(
        .NUM_LEDS       (NL),
        .CLK_HZ         (1000),
        .TICK_HZ        (100),
        .PWM_BITS       (4),
        .PERIOD_W       (16),
        .DEFAULT_PERIOD (500)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_chan_i   (cfg_chan_i),
        .cfg_mode_i   (cfg_mode_i),
        .cfg_period_i (cfg_period_i),
        .cfg_err_o    (cfg_err_o),
        .tick_o       (tick_o),
        .led_o        (led_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: edges since reset release plus, per channel, the
    // number of ticks seen since the last write.
    int          cyc;
    int          m_mode  [NL];
    int          m_per   [NL];
    int          m_ticks [NL];
    logic [NL-1:0] e_led;
    logic          e_err;

    typedef struct {
        logic [2:0]    ch;
        logic [1:0]    md;
        logic [NL-1:0] exp_led;
        logic          exp_err;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic mled(input int n, input int pwm);
        int eff, s, d, duty;
        eff = (m_per[n] == 0) ? 1 : m_per[n];
        s   = m_ticks[n] / eff;
        case (m_mode[n])
            0: return 1'b0;
            1: return 1'b1;
            2: return logic'(s % 2);
            default: begin
                // Triangle 0..15, hold 15, 14..0, hold 0: repeats every 32 steps.
                d    = s % 32;
                duty = (d <= 15) ? d : 31 - d;
                return pwm < duty;
            end
        endcase
    endfunction

    task automatic model_reset();
        cyc   = 0;
        e_led = '0;
        e_err = 1'b0;
        for (int n = 0; n < NL; n++) begin
            m_mode[n]  = 0;
            m_per[n]   = 500;
            m_ticks[n] = 0;
        end
    endtask

    // Called at a negedge: drive inputs, predict the next edge, check at the next negedge.
    task automatic step(input logic v, input logic [2:0] ch, input logic [1:0] md,
                        input logic [15:0] per);
        logic tick, acc;
        logic [NL-1:0] nled;
        cfg_valid_i  = v;
        cfg_chan_i   = ch;
        cfg_mode_i   = md;
        cfg_period_i = per;
        tick = (cyc % 10 == 9);
        acc  = v && (cyc >= 1);
        for (int n = 0; n < NL; n++) nled[n] = mled(n, cyc % 16);
        for (int n = 0; n < NL; n++) begin
            if (acc && int'(ch) == n) begin
                m_mode[n]  = int'(md);
                m_per[n]   = int'(per);
                m_ticks[n] = 0;
            end else if (tick && m_mode[n] >= 2) begin
                m_ticks[n]++;
            end
        end
        e_err = acc && (int'(ch) >= NL);
        e_led = nled;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        cfg_valid_i = 1'b0;
        chk("led_o", 32'(led_o), 32'(e_led));
        chk("cfg_err_o", 32'(cfg_err_o), 32'(e_err));
        chk("cfg_ready_o", 32'(cfg_ready_o), 32'(cyc >= 1));
        chk("tick_o", 32'(tick_o), 32'(cyc % 10 == 9));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 2'd0, 16'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        chk("rst_led", 32'(led_o), 32'd0);
        chk("rst_ready", 32'(cfg_ready_o), 32'd0);
        chk("rst_tick", 32'(tick_o), 32'd0);
        chk("rst_err", 32'(cfg_err_o), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        vt[0] = '{ch: 3'd1, md: 2'd1, exp_led: 3'b010, exp_err: 1'b0};
        vt[1] = '{ch: 3'd1, md: 2'd0, exp_led: 3'b000, exp_err: 1'b0};
        vt[2] = '{ch: 3'd0, md: 2'd1, exp_led: 3'b001, exp_err: 1'b0};
        vt[3] = '{ch: 3'd5, md: 2'd1, exp_led: 3'b001, exp_err: 1'b1};
        vt[4] = '{ch: 3'd2, md: 2'd1, exp_led: 3'b101, exp_err: 1'b0};
        vt[5] = '{ch: 3'd7, md: 2'd0, exp_led: 3'b101, exp_err: 1'b1};
        vt[6] = '{ch: 3'd0, md: 2'd0, exp_led: 3'b100, exp_err: 1'b0};
        vt[7] = '{ch: 3'd2, md: 2'd0, exp_led: 3'b000, exp_err: 1'b0};

        @(negedge clk);
        do_reset();
        idle(25);

        // Directed ON/OFF/error table; each write shows up one edge later.
        foreach (vt[i]) begin
            step(1'b1, vt[i].ch, vt[i].md, 16'd7);
            step(1'b0, 3'd0, 2'd0, 16'd0);
            chk("tbl_led", 32'(led_o), 32'(vt[i].exp_led));
        end
        step(1'b1, 3'd6, 2'd1, 16'd1);
        chk("err_pulse", 32'(cfg_err_o), 32'd1);
        step(1'b0, 3'd0, 2'd0, 16'd0);
        chk("err_clear", 32'(cfg_err_o), 32'd0);

        // BLINK period 3, then period 0.
        step(1'b1, 3'd0, 2'd2, 16'd3);
        idle(90);
        step(1'b1, 3'd0, 2'd2, 16'd0);
        idle(45);

        // BREATHE on chan2, period 1: full up/down triangle and beyond.
        step(1'b1, 3'd2, 2'd3, 16'd1);
        idle(360);

        // Write to chan0 in the tick cycle: counter restarts instead of advancing.
        while (cyc % 10 != 9) step(1'b0, 3'd0, 2'd0, 16'd0);
        step(1'b1, 3'd0, 2'd2, 16'd1);
        idle(30);

        // Back-to-back writes to every channel.
        step(1'b1, 3'd0, 2'd1, 16'd2);
        step(1'b1, 3'd1, 2'd2, 16'd1);
        step(1'b1, 3'd2, 2'd3, 16'd2);
        idle(60);

        // Random config traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 29) == 0)
                step(1'b1, 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     16'($urandom_range(0, 3)));
            else
                step(1'b0, 3'd0, 2'd0, 16'd0);
        end

        // Async reset in the middle of a blink while led_o[0] is high.
        step(1'b1, 3'd0, 2'd2, 16'd1);
        for (int i = 0; i < 100 && e_led[0] !== 1'b1; i++) step(1'b0, 3'd0, 2'd0, 16'd0);
        chk("pre_rst_led0", 32'(led_o[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_led", 32'(led_o), 32'd0);
        chk("async_rst_ready", 32'(cfg_ready_o), 32'd0);
        @(negedge clk);
        do_reset();
        idle(40);
        chk("post_rst_off", 32'(led_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
